// File: rtl/barrel_shift_pkg.sv
// Shared types, default widths and stage-count helper for the pipelined barrel shifter.
package barrel_shift_pkg;

    typedef enum logic {
        SHIFT_LEFT  = 1'b0,
        SHIFT_RIGHT = 1'b1
    } shift_dir_e;

    localparam int unsigned WIDTH_DEF      = 196;
    localparam int unsigned I_WIDTH_DEF    = 128;
    localparam int unsigned SHIFT_BIT_DEF  = 7;
    localparam int unsigned PIPE_EVERY_DEF = 2;
    localparam int unsigned TAG_W_DEF      = 8;

    // Number of register stages needed to cover every shift level.
    function automatic int unsigned calc_nreg(input int unsigned shift_bit,
                                              input int unsigned pipe_every);
        return (shift_bit + pipe_every - 1) / pipe_every;
    endfunction

endpackage

// File: rtl/bsp_stage.sv
// One pipeline stage: LVL_N shift levels starting at level LVL_LO, then the stage register.
// BARREL_SHIFTER_PIPE_RIGHT_EN adds per-beat direction (right-shift mux and dir register).
module bsp_stage
    import barrel_shift_pkg::*;
#(
    parameter int unsigned WIDTH     = WIDTH_DEF,
    parameter int unsigned SHIFT_BIT = SHIFT_BIT_DEF,
    parameter int unsigned TAG_W     = TAG_W_DEF,
    parameter int unsigned LVL_LO    = 0,
    parameter int unsigned LVL_N     = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 en,
    input  logic                 valid_i,
    input  logic [WIDTH-1:0]     word_i,
    input  logic [SHIFT_BIT-1:0] amt_i,
`ifdef BARREL_SHIFTER_PIPE_RIGHT_EN
    input  shift_dir_e           dir_i,
    output shift_dir_e           dir_o,
`endif
    input  logic [TAG_W-1:0]     tag_i,
    output logic                 valid_o,
    output logic [WIDTH-1:0]     word_o,
    output logic [SHIFT_BIT-1:0] amt_o,
    output logic [TAG_W-1:0]     tag_o
);

    // Amount bits consumed by this stage; cleared before being handed on.
    localparam logic [SHIFT_BIT-1:0] LVL_MASK =
        SHIFT_BIT'(((64'd1 << LVL_N) - 64'd1) << LVL_LO);

    logic [LVL_N-1:0]     rem_c;
    logic [WIDTH-1:0]     shift_c;
    logic                 valid_d, valid_q;
    logic [WIDTH-1:0]     word_d, word_q;
    logic [SHIFT_BIT-1:0] amt_d, amt_q;
    logic [TAG_W-1:0]     tag_d, tag_q;
`ifdef BARREL_SHIFTER_PIPE_RIGHT_EN
    shift_dir_e           dir_d, dir_q;
`endif

    // Shift levels; a level of 2^k >= WIDTH naturally yields zero.
    always_comb begin
        rem_c   = amt_i[LVL_LO +: LVL_N];
        shift_c = word_i;
        for (int unsigned k = 0; k < LVL_N; k++) begin
            if (rem_c[0]) begin
`ifdef BARREL_SHIFTER_PIPE_RIGHT_EN
                if (dir_i == SHIFT_RIGHT) begin
                    shift_c = shift_c >> (1 << (LVL_LO + k));
                end else begin
                    shift_c = shift_c << (1 << (LVL_LO + k));
                end
`else
                shift_c = shift_c << (1 << (LVL_LO + k));
`endif
            end
            rem_c = rem_c >> 1;
        end
    end

    always_comb begin
        valid_d = flush ? 1'b0 : (en ? valid_i : valid_q);
        word_d  = en ? shift_c : word_q;
        amt_d   = en ? (amt_i & ~LVL_MASK) : amt_q;
        tag_d   = en ? tag_i : tag_q;
`ifdef BARREL_SHIFTER_PIPE_RIGHT_EN
        dir_d   = en ? dir_i : dir_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            word_q  <= '0;
            amt_q   <= '0;
            tag_q   <= '0;
`ifdef BARREL_SHIFTER_PIPE_RIGHT_EN
            dir_q   <= SHIFT_LEFT;
`endif
        end else begin
            valid_q <= valid_d;
            word_q  <= word_d;
            amt_q   <= amt_d;
            tag_q   <= tag_d;
`ifdef BARREL_SHIFTER_PIPE_RIGHT_EN
            dir_q   <= dir_d;
`endif
        end
    end

    assign valid_o = valid_q;
    assign word_o  = word_q;
    assign amt_o   = amt_q;
    assign tag_o   = tag_q;
`ifdef BARREL_SHIFTER_PIPE_RIGHT_EN
    assign dir_o   = dir_q;
`endif

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined logical barrel shifter with valid/ready, tag sideband and synchronous flush.
// BARREL_SHIFTER_PIPE_RIGHT_EN enables per-beat right shifts via i_dir; otherwise all beats shift left.
module barrel_shifter_pipe
    import barrel_shift_pkg::*;
#(
    parameter int unsigned WIDTH      = WIDTH_DEF,
    parameter int unsigned I_WIDTH    = I_WIDTH_DEF,
    parameter int unsigned SHIFT_BIT  = SHIFT_BIT_DEF,
    parameter int unsigned PIPE_EVERY = PIPE_EVERY_DEF,
    parameter int unsigned TAG_W      = TAG_W_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_flush,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [I_WIDTH-1:0]   i_word,
    input  logic [SHIFT_BIT-1:0] i_amt,
    input  logic                 i_dir,
    input  logic [TAG_W-1:0]     i_tag,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [WIDTH-1:0]     o_word,
    output logic [TAG_W-1:0]     o_tag
);

    localparam int unsigned NREG = calc_nreg(SHIFT_BIT, PIPE_EVERY);

    logic                 en_c;
    logic                 acc_c;
    logic                 valid_c [1:NREG];
    logic [WIDTH-1:0]     word_c  [0:NREG];
    logic [SHIFT_BIT-1:0] amt_c   [0:NREG];
    logic [TAG_W-1:0]     tag_c   [0:NREG];
    logic [SHIFT_BIT-1:0] unused_amt;

    // Whole pipe advances together; bubbles are kept, not collapsed.
    assign en_c      = !o_valid || i_ready;
    assign o_ready   = en_c && !i_flush;
    assign acc_c     = i_valid && o_ready;
    assign word_c[0] = WIDTH'(i_word);
    assign amt_c[0]  = i_amt;
    assign tag_c[0]  = i_tag;

`ifdef BARREL_SHIFTER_PIPE_RIGHT_EN
    shift_dir_e dir_c [0:NREG];
    shift_dir_e unused_dir;
    assign dir_c[0]   = shift_dir_e'(i_dir);
    assign unused_dir = dir_c[NREG];
`else
    logic unused_dir;
    assign unused_dir = i_dir;
`endif

    for (genvar i = 0; i < NREG; i++) begin : g_stage
        localparam int unsigned LO = i * PIPE_EVERY;
        localparam int unsigned N  = (SHIFT_BIT - LO < PIPE_EVERY) ? (SHIFT_BIT - LO) : PIPE_EVERY;

        logic vin;
        if (i == 0) begin : g_head
            assign vin = acc_c;
        end else begin : g_body
            assign vin = valid_c[i];
        end

        bsp_stage #(
            .WIDTH     (WIDTH),
            .SHIFT_BIT (SHIFT_BIT),
            .TAG_W     (TAG_W),
            .LVL_LO    (LO),
            .LVL_N     (N)
        ) u_stage (
            .clk     (i_clk),
            .rst_n   (i_rst_n),
            .flush   (i_flush),
            .en      (en_c),
            .valid_i (vin),
            .word_i  (word_c[i]),
            .amt_i   (amt_c[i]),
`ifdef BARREL_SHIFTER_PIPE_RIGHT_EN
            .dir_i   (dir_c[i]),
            .dir_o   (dir_c[i+1]),
`endif
            .tag_i   (tag_c[i]),
            .valid_o (valid_c[i+1]),
            .word_o  (word_c[i+1]),
            .amt_o   (amt_c[i+1]),
            .tag_o   (tag_c[i+1])
        );
    end

    // Residual amount after the last stage is always fully consumed.
    assign unused_amt = amt_c[NREG];

    assign o_valid = valid_c[NREG];
    assign o_word  = word_c[NREG];
    assign o_tag   = tag_c[NREG];

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Directed bench for barrel_shifter_pipe with an in-order scoreboard of expected beats.
module tb_barrel_shifter_pipe;

    localparam int unsigned W  = 196;
    localparam int unsigned IW = 128;
    localparam int unsigned SB = 7;
    localparam int unsigned PE = 2;
    localparam int unsigned TW = 8;
`ifdef BARREL_SHIFTER_PIPE_RIGHT_EN
    localparam logic RIGHT_EN = 1'b1;
`else
    localparam logic RIGHT_EN = 1'b0;
`endif

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic          i_flush;
    logic          i_valid;
    logic          o_ready;
    logic [IW-1:0] i_word;
    logic [SB-1:0] i_amt;
    logic          i_dir;
    logic [TW-1:0] i_tag;
    logic          o_valid;
    logic          i_ready;
    logic [W-1:0]  o_word;
    logic [TW-1:0] o_tag;

    typedef struct packed {
        logic [W-1:0]  word;
        logic [TW-1:0] tag;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    int   pops   = 0;
    logic acc_seen;

    always #5 i_clk = ~i_clk;

    barrel_shifter_pipe #(
        .WIDTH      (W),
        .I_WIDTH    (IW),
        .SHIFT_BIT  (SB),
        .PIPE_EVERY (PE),
        .TAG_W      (TW)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (i_flush),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_word  (i_word),
        .i_amt   (i_amt),
        .i_dir   (i_dir),
        .i_tag   (i_tag),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_word  (o_word),
        .o_tag   (o_tag)
    );

    // Reference: zero-extend, then one logical shift by the whole amount.
    function automatic logic [W-1:0] model(input logic [IW-1:0] w, input logic [SB-1:0] a, input logic d);
        logic [W-1:0] x;
        logic         right;
        x     = W'(w);
        right = d & RIGHT_EN;
        if (32'(a) >= W) return '0;
        if (right) return x >> a;
        return x << a;
    endfunction

    task automatic check(input string name, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // One clock: score the output handshake, record an accepted input, advance.
    task automatic tick();
        exp_t e;
        @(negedge i_clk);
        acc_seen = i_valid && o_ready;
        if (o_valid === 1'b1 && i_ready) begin
            if (sb_q.size() == 0) begin
                check("stray_beat", W'(o_valid), '0);
            end else begin
                e = sb_q.pop_front();
                pops++;
                check("sb_word", o_word, e.word);
                check("sb_tag", W'(o_tag), W'(e.tag));
            end
        end
        if (!i_rst_n || i_flush) begin
            sb_q.delete();
        end else if (acc_seen) begin
            e.word = model(i_word, i_amt, i_dir);
            e.tag  = i_tag;
            sb_q.push_back(e);
        end
        @(posedge i_clk);
        #1;
    endtask

    // Single beat into an empty pipe; checks exact 4-edge latency and the explicit result.
    task automatic send_lat(input string name, input logic [IW-1:0] w, input logic [SB-1:0] a,
                            input logic d, input logic [TW-1:0] t, input logic [W-1:0] exp_word);
        i_valid = 1'b1; i_word = w; i_amt = a; i_dir = d; i_tag = t; i_ready = 1'b1;
        tick();
        check({name, "_acc"}, W'(acc_seen), W'(1));
        i_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check({name, "_early"}, W'(o_valid), '0);
            tick();
        end
        check({name, "_valid"}, W'(o_valid), W'(1));
        check({name, "_word"}, o_word, exp_word);
        check({name, "_tag"}, W'(o_tag), W'(t));
        tick();
    endtask

    initial begin
        int            sent;
        int            stall_left;
        int            pops0;
        logic          did_stall;
        logic [W-1:0]  held_w;
        logic [W-1:0]  expw;
        logic [TW-1:0] held_t;

        i_rst_n = 1'b0; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
        i_word = '0; i_amt = '0; i_dir = 1'b0; i_tag = '0;
        tick();
        tick();
        i_rst_n = 1'b1;
        check("rst_ovalid", W'(o_valid), '0);
        check("rst_oword", o_word, '0);
        check("rst_otag", W'(o_tag), '0);
        check("rst_oready", W'(o_ready), W'(1));

        expw = '0; expw[127] = 1'b1;
        send_lat("left127", IW'(1), SB'(127), 1'b0, 8'h5A, expw);

        expw = '0;
        for (int b = 100; b < int'(W); b++) expw[b] = 1'b1;
        send_lat("topdrop", '1, SB'(100), 1'b0, 8'h3C, expw);

        expw = '0;
`ifdef BARREL_SHIFTER_PIPE_RIGHT_EN
        expw[120] = 1'b1;
`else
        expw[134] = 1'b1;
`endif
        send_lat("right7", IW'(1) << 127, SB'(7), 1'b1, 8'hC3, expw);

        expw = '0; expw[IW-1:0] = {4{32'hDEADBEEF}};
        send_lat("amt0", {4{32'hDEADBEEF}}, SB'(0), 1'b1, 8'h01, expw);

        // Backpressure: stall 3 cycles once tag 1 reaches the output.
        sent = 0; stall_left = 0; did_stall = 1'b0; pops0 = pops;
        held_w = '0; held_t = '0;
        for (int c = 0; c < 40; c++) begin
            i_valid = (sent < 6);
            i_word  = {4{32'(sent) * 32'h01010101}};
            i_amt   = SB'(sent * 9);
            i_dir   = sent[0];
            i_tag   = TW'(sent);
            if (!did_stall && o_valid && o_tag == 8'd1) begin
                did_stall = 1'b1; stall_left = 3; held_w = o_word; held_t = o_tag;
            end
            i_ready = (stall_left == 0);
            #1;
            if (stall_left > 0) begin
                check("bp_oready", W'(o_ready), '0);
                check("bp_ovalid", W'(o_valid), W'(1));
                check("bp_word", o_word, held_w);
                check("bp_tag", W'(o_tag), W'(held_t));
                stall_left--;
            end
            tick();
            if (acc_seen) sent++;
        end
        i_valid = 1'b0; i_ready = 1'b1;
        check("bp_stalled", W'(did_stall), W'(1));
        check("bp_count", W'(pops - pops0), W'(6));

        // Flush with three beats in flight and a fourth offered.
        for (int k = 0; k < 3; k++) begin
            i_valid = 1'b1; i_word = {$urandom, $urandom, $urandom, $urandom};
            i_amt = SB'($urandom); i_dir = 1'b0; i_tag = TW'(8'h10 + k);
            tick();
        end
        i_valid = 1'b1; i_tag = 8'h13; i_flush = 1'b1;
        #1;
        check("flush_oready", W'(o_ready), '0);
        tick();
        i_flush = 1'b0; i_valid = 1'b0;
        check("flush_ovalid", W'(o_valid), '0);
        for (int k = 0; k < 8; k++) begin
            tick();
            check("flush_idle", W'(o_valid), '0);
        end
        expw = '0; expw[IW+3:4] = {4{32'h12345678}};
        send_lat("postflush", {4{32'h12345678}}, SB'(4), 1'b0, 8'h20, expw);

        // Reset with the pipe full.
        for (int k = 0; k < 4; k++) begin
            i_valid = 1'b1; i_word = {$urandom, $urandom, $urandom, $urandom};
            i_amt = SB'($urandom); i_dir = 1'b0; i_tag = TW'(8'h30 + k);
            tick();
        end
        check("full_ovalid", W'(o_valid), W'(1));
        i_valid = 1'b1; i_rst_n = 1'b0;
        tick();
        i_rst_n = 1'b1; i_valid = 1'b0;
        check("mrst_ovalid", W'(o_valid), '0);
        check("mrst_oword", o_word, '0);
        check("mrst_otag", W'(o_tag), '0);
        check("mrst_oready", W'(o_ready), W'(1));
        for (int k = 0; k < 8; k++) begin
            tick();
            check("mrst_idle", W'(o_valid), '0);
        end

        // Random traffic with random backpressure, then bounded drain.
        for (int c = 0; c < 120; c++) begin
            i_valid = 1'($urandom_range(0, 1));
            i_ready = ($urandom_range(0, 3) != 0);
            i_word  = {$urandom, $urandom, $urandom, $urandom};
            i_amt   = SB'($urandom);
            i_dir   = 1'($urandom_range(0, 1));
            i_tag   = TW'($urandom);
            tick();
        end
        i_valid = 1'b0; i_ready = 1'b1;
        for (int k = 0; k < 40 && sb_q.size() != 0; k++) tick();
        check("drain_empty", W'(sb_q.size()), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/barrel_shifter_pipe.md
# barrel_shifter_pipe

Pipelined, parametrised barrel shifter for the word-decompression datapath. Zero-extends an `I_WIDTH` input word into a `WIDTH` window and shifts it by a per-beat amount. Register stages are inserted every `PIPE_EVERY` shift levels. Beats carry a sideband tag and use a valid/ready handshake with backpressure and a synchronous flush. It sits between the decoded-symbol queue and the output word assembler, and replaces the single-cycle combinational shifter where timing fails at the decompressor clock.

## Interface
- `WIDTH`, 196, output window width in bits.
- `I_WIDTH`, 128, input word width; must be ≤ `WIDTH`.
- `SHIFT_BIT`, 7, shift-amount width; one shift level per bit.
- `PIPE_EVERY`, 2, shift levels per register stage; ≥ 1. `NREG = ceil(SHIFT_BIT/PIPE_EVERY)`.
- `TAG_W`, 8, sideband tag width.

Ports:
- `i_clk`  in  1  clock.
- `i_rst_n`  in  1  synchronous, active-low reset.
- `i_flush`  in  1  synchronous pipeline clear.
- `i_valid`  in  1  input beat valid.
- `o_ready`  out  1  block accepts input this cycle.
- `i_word`  in  `I_WIDTH`  data word.
- `i_amt`  in  `SHIFT_BIT`  shift amount.
- `i_dir`  in  1  0 = left, 1 = right (see Configuration).
- `i_tag`  in  `TAG_W`  sideband, passed through unchanged.
- `o_valid`  out  1  output beat valid.
- `i_ready`  in  1  downstream accepts output.
- `o_word`  out  `WIDTH`  shifted word.
- `o_tag`  out  `TAG_W`  tag of the current output beat.

## Operation
- Input word is zero-extended to `WIDTH`. Shift level k shifts by 2^k when `i_amt[k]` is 1.
  - Logical shift; vacated bits are 0.
  - Bits shifted past bit `WIDTH-1` (left) or below bit 0 (right) are dropped.
- If an amount is ≥ `WIDTH` (only possible when 2^`SHIFT_BIT` > `WIDTH`), the result is all zero.
- Each register stage holds: partial word, the unconsumed amount bits, dir, tag and a valid bit.
- Global advance: `en = !o_valid || i_ready`. Every stage loads from its predecessor when `en` is 1 and holds when `en` is 0.
  - Bubbles are not collapsed.
- `o_ready = en && !i_flush`. A beat is accepted when `i_valid && o_ready`. If `i_valid` is 0 while `en` is 1, a bubble (valid = 0) enters stage 0.
- Flush: when `i_flush` is 1, all stage valid bits clear at the next edge. Data registers may keep stale values. No input is accepted that cycle.
- Simultaneous events:
  - flush + `i_valid`: the input is dropped.
  - flush + `i_ready`: the current output is still considered consumed. No new output appears.
- Beat order is strictly preserved. Tag and dir travel with their word.

## Timing
- Latency: a beat accepted at edge t appears on `o_valid` / `o_word` / `o_tag` after `NREG` advancing edges. With defaults, `NREG` = 4, so the beat is presented 4 cycles later when there are no stalls.
- Throughput: 1 beat/cycle while `i_ready` is held high.
- While `o_valid && !i_ready`: `o_word`, `o_tag` and `o_valid` stay stable and `o_ready` is 0. This is combinational from `i_ready`.
- Reset (`i_rst_n` low at an edge): all valid bits, `o_valid`, `o_word` and `o_tag` go to 0. In-flight beats are lost.
- `o_ready` is 1 in the first cycle after reset releases.
- Reset and flush asserted together behave as reset.

## Configuration
- `BARREL_SHIFTER_PIPE_RIGHT_EN` defined: `i_dir` selects left or right per beat. Each level is a 3:1 mux (pass / left / right).
- Undefined: `i_dir` is ignored; every beat is a left shift. The right-shift logic and the per-stage dir register are not built.
- Port list is identical in both builds.

## Structure
- Package `barrel_shift_pkg`:
  - `shift_dir_e` typedef (`SHIFT_LEFT` = 1'b0, `SHIFT_RIGHT` = 1'b1).
  - Default width constants.
  - Function computing `NREG` from `SHIFT_BIT` and `PIPE_EVERY`.
- Sub-module `bsp_stage`: up to `PIPE_EVERY` combinational shift levels followed by the stage register (word, remaining amount, dir, tag, valid). Instantiated `NREG` times by a generate loop. The last instance may hold fewer levels.

## Test plan
- Basic left shift: `i_word`=1, `i_amt`=127, left, `i_tag`=8'h5A, `i_ready`=1 → 4 cycles later `o_valid`=1, only `o_word[127]` set, `o_tag`=8'h5A.
- Top-bit drop: `i_word`=all-ones (128 bits), `i_amt`=100, left → `o_word[195:100]` all ones, `o_word[99:0]` = 0.
- Right shift (macro on): `i_word`=1<<127, `i_amt`=7, right → only `o_word[120]` set. Same stimulus with macro off → only `o_word[134]` set.
- Backpressure: 6 back-to-back beats with tags 0..5; drop `i_ready` for 3 cycles when tag 1 is on the output → `o_word` / `o_tag` stable, `o_ready`=0 during the stall; all 6 tags delivered in order, no duplicates.
- Flush: 3 beats in flight, assert `i_flush` for one cycle with `i_valid`=1 → `o_valid`=0 next cycle, none of the 4 beats ever appears, next accepted beat emerges with 4-cycle latency.
- Reset mid-stream: `i_rst_n`=0 for one cycle with the pipe full → all outputs 0 next cycle, `o_ready`=1, no stale beat emitted.
